// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: IF->OF word handshake and OF->EX bundle handshake.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid & ready are both high; the sender holds valid and payload stable
// until that edge, and ready may depend combinationally on the sender's valid
// side but never the other way round.
interface operand_fetch_if;
    logic        if_of_valid;
    logic [15:0] if_of_instr;
    logic        of_if_ready;
    logic        of_ex_valid;
    logic        ex_of_ready;
    logic [4:0]  of_ex_op;
    logic [15:0] of_ex_operand_a;
    logic [15:0] of_ex_operand_b;
    logic [4:0]  of_ex_reg_idx_dst;

    // Environment side: drives IF words and EX ready, observes the OF stage.
    modport master (
        output if_of_valid, if_of_instr, ex_of_ready,
        input  of_if_ready, of_ex_valid, of_ex_op,
        input  of_ex_operand_a, of_ex_operand_b, of_ex_reg_idx_dst
    );

    // Operand-fetch stage side.
    modport slave (
        input  if_of_valid, if_of_instr, ex_of_ready,
        output of_if_ready, of_ex_valid, of_ex_op,
        output of_ex_operand_a, of_ex_operand_b, of_ex_reg_idx_dst
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes 16-bit words, reads/forwards register operands,
// assembles a second-word immediate, and presents a registered bundle to EX.
// Applies a one-cycle load-use interlock and a synchronous branch flush.
// Optional macro OF_ZERO_REG_EN: register 0 reads as zero, never forwards and
// never interlocks.
module operand_fetch #(
    parameter int         NREG    = 16,
    parameter logic [4:0] LOAD_OP = 5'b10010
) (
    input  logic        clk,
    input  logic        reset,
    operand_fetch_if.slave bus,
    input  logic        flush,
    output logic [4:0]  rf_a_idx,
    input  logic [15:0] rf_a_data,
    output logic [4:0]  rf_b_idx,
    input  logic [15:0] rf_b_data,
    input  logic        ex_fwd_en,
    input  logic [4:0]  ex_fwd_idx,
    input  logic [15:0] ex_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_idx,
    input  logic [15:0] wb_fwd_data,
    output logic        dbg_state
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic {
        DECODE = 1'b0,
        IMM    = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  hold_op_q, hold_op_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic        ld_pend_q, ld_pend_d;
    logic [4:0]  ld_idx_q, ld_idx_d;
    logic        valid_q, valid_d;
    logic [4:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  dst_q, dst_d;

    logic [4:0]  dec_op, dec_rd, dec_rs;
    logic        dec_imm;
    logic        slot_free, interlock, accept, transfer;
    logic [15:0] fwd_a, fwd_b;
    logic        unused_bits;

    // Field extraction; the two low bits are reserved and ignored.
    assign dec_op      = bus.if_of_instr[15:11];
    assign dec_rd      = 5'(bus.if_of_instr[7 +: IDX_W]);
    assign dec_rs      = 5'(bus.if_of_instr[3 +: IDX_W]);
    assign dec_imm     = bus.if_of_instr[2];
    assign unused_bits = ^bus.if_of_instr[1:0];

    // Operand select per read port: EX result beats WB data beats regfile.
    function automatic logic [15:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [15:0] rf_data,
        input logic        ex_en,
        input logic [4:0]  ex_idx,
        input logic [15:0] ex_data,
        input logic        wb_en,
        input logic [4:0]  wb_idx,
        input logic [15:0] wb_data
    );
        logic        is_zero;
        logic [15:0] r;
        is_zero = 1'b0;
`ifdef OF_ZERO_REG_EN
        is_zero = (idx == 5'd0);
`endif
        if (is_zero)
            r = 16'h0000;
        else if (ex_en && (ex_idx == idx))
            r = ex_data;
        else if (wb_en && (wb_idx == idx))
            r = wb_data;
        else
            r = rf_data;
        return r;
    endfunction

    // Register file read indices: decoded fields in DECODE, held rd in IMM.
    always_comb begin
        rf_a_idx = dec_rd;
        rf_b_idx = dec_rs;
        if (state_q == IMM) begin
            rf_a_idx = hold_rd_q;
            rf_b_idx = 5'd0;
        end
    end

    assign fwd_a = fwd_sel(rf_a_idx, rf_a_data, ex_fwd_en, ex_fwd_idx, ex_fwd_data,
                           wb_fwd_en, wb_fwd_idx, wb_fwd_data);
    assign fwd_b = fwd_sel(rf_b_idx, rf_b_data, ex_fwd_en, ex_fwd_idx, ex_fwd_data,
                           wb_fwd_en, wb_fwd_idx, wb_fwd_data);

    // Load-use interlock: a DECODE word reading the just-issued load target waits a cycle.
    always_comb begin
        logic ld_hit;
        ld_hit = ld_pend_q &&
                 ((dec_rd == ld_idx_q) || (!dec_imm && (dec_rs == ld_idx_q)));
`ifdef OF_ZERO_REG_EN
        ld_hit = ld_hit && (ld_idx_q != 5'd0);
`endif
        interlock = (state_q == DECODE) && ld_hit;
    end

    assign slot_free       = !valid_q || bus.ex_of_ready;
    assign transfer        = valid_q && bus.ex_of_ready;
    assign bus.of_if_ready = slot_free && !interlock && !flush;
    assign accept          = bus.if_of_valid && bus.of_if_ready;

    // Next-state and bundle assembly; flush overrides everything but reset.
    always_comb begin
        state_d   = state_q;
        hold_op_d = hold_op_q;
        hold_rd_d = hold_rd_q;
        valid_d   = valid_q && !transfer;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        ld_pend_d = transfer && (op_q == LOAD_OP);
        ld_idx_d  = ld_idx_q;
        if (transfer && (op_q == LOAD_OP))
            ld_idx_d = dst_q;

        if (flush) begin
            valid_d   = 1'b0;
            state_d   = DECODE;
            ld_pend_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                DECODE: begin
                    if (!dec_imm) begin
                        op_d    = dec_op;
                        a_d     = fwd_a;
                        b_d     = fwd_b;
                        dst_d   = dec_rd;
                        valid_d = 1'b1;
                    end else begin
                        hold_op_d = dec_op;
                        hold_rd_d = dec_rd;
                        state_d   = IMM;
                    end
                end
                IMM: begin
                    op_d    = hold_op_q;
                    a_d     = fwd_a;
                    b_d     = bus.if_of_instr;
                    dst_d   = hold_rd_q;
                    valid_d = 1'b1;
                    state_d = DECODE;
                end
                default: state_d = DECODE;
            endcase
        end
    end

    // State and bundle registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= DECODE;
            hold_op_q <= '0;
            hold_rd_q <= '0;
            ld_pend_q <= 1'b0;
            ld_idx_q  <= '0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_op_q <= hold_op_d;
            hold_rd_q <= hold_rd_d;
            ld_pend_q <= ld_pend_d;
            ld_idx_q  <= ld_idx_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dst_q     <= dst_d;
        end
    end

    assign bus.of_ex_valid       = valid_q;
    assign bus.of_ex_op          = op_q;
    assign bus.of_ex_operand_a   = a_q;
    assign bus.of_ex_operand_b   = b_q;
    assign bus.of_ex_reg_idx_dst = dst_q;
    assign dbg_state             = state_q;

endmodule
